// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system constants: default RAM word/address widths and core-index sizing.
package mem_arbiter_pkg;

    localparam int unsigned MEM_DATA_W  = 16;
    localparam int unsigned MEM_ADDR_W  = 12;
    localparam int unsigned MEM_N_CORES = 8;
    localparam int unsigned CORE_IDX_W  = (MEM_N_CORES > 1) ? $clog2(MEM_N_CORES) : 1;

    // Width of an encoded core index for n requesters (never zero).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Stateless round-robin selector: first requester at or above p, wrapping to 0.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N  = MEM_N_CORES,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] p,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan N positions starting at p, keep the first active request.
    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, p} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among N_CORES requesters.
// Read data returns two cycles after the grant on a shared rdata bus.
// Optional bus locking is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CORES    = MEM_N_CORES,
    parameter int unsigned Data_width = MEM_DATA_W,
    parameter int unsigned Addr_width = MEM_ADDR_W
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_CORES-1:0]             req,
    input  logic [N_CORES-1:0]             we,
    input  logic [N_CORES*Addr_width-1:0]  addr,
    input  logic [N_CORES*Data_width-1:0]  din,
`ifdef MEM_ARB_LOCK_EN
    input  logic [N_CORES-1:0]             lock,
`endif
    output logic [N_CORES-1:0]             gnt,
    output logic [N_CORES-1:0]             rvalid,
    output logic [Data_width-1:0]          rdata,
    output logic                           mem_we,
    output logic [Addr_width-1:0]          mem_addr,
    output logic [Data_width-1:0]          mem_din,
    input  logic [Data_width-1:0]          mem_dout
);

    localparam int unsigned IW = idx_w(N_CORES);

    logic [IW-1:0]         ptr_q;
    logic [IW-1:0]         ptr_d;
    logic [N_CORES-1:0]    req_elig;
    logic [N_CORES-1:0]    pick_gnt;
    logic [IW-1:0]         winner;
    logic                  any_gnt;

    logic                  win_we;
    logic [Addr_width-1:0] win_addr;
    logic [Data_width-1:0] win_din;

    logic                  pend0_vld_q;
    logic [IW-1:0]         pend0_idx_q;
    logic                  pend1_vld_q;
    logic [IW-1:0]         pend1_idx_q;

`ifdef MEM_ARB_LOCK_EN
    logic                  own_q;
    logic [IW-1:0]         owner_q;
    logic [N_CORES-1:0]    owner_mask;

    // Decode the current owner into a request mask.
    always_comb begin
        owner_mask = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            owner_mask[i] = (owner_q == IW'(i));
        end
    end

    // Ownership follows the lock bit sampled on each grant to the owner.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            own_q   <= 1'b0;
            owner_q <= '0;
        end else if (any_gnt) begin
            own_q   <= lock[winner];
            owner_q <= winner;
        end
    end

    // Eligible requests: none in reset, only the owner while locked.
    always_comb begin
        req_elig = rstn ? req : '0;
        if (own_q) begin
            req_elig = req_elig & owner_mask;
        end
    end
`else
    // Eligible requests: none while reset is asserted.
    always_comb begin
        req_elig = rstn ? req : '0;
    end
`endif

    rr_picker #(
        .N  (N_CORES),
        .IW (IW)
    ) u_picker (
        .req    (req_elig),
        .p      (ptr_q),
        .gnt    (pick_gnt),
        .winner (winner)
    );

    assign gnt     = pick_gnt;
    assign any_gnt = |pick_gnt;
    assign rdata   = mem_dout;

    // Select the winning core's command fields.
    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        win_din  = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            if (winner == IW'(i)) begin
                win_we   = we[i];
                win_addr = addr[i*Addr_width +: Addr_width];
                win_din  = din[i*Data_width +: Data_width];
            end
        end
    end

    // Next pointer: one past the winner, wrapping; hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
            if (winner == IW'(N_CORES - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + IW'(1);
            end
        end
    end

    // Read-valid strobe for the read that has finished its two-cycle trip.
    always_comb begin
        rvalid = '0;
        if (rstn && pend1_vld_q) begin
            for (int unsigned i = 0; i < N_CORES; i++) begin
                rvalid[i] = (pend1_idx_q == IW'(i));
            end
        end
    end

    // Pointer, RAM command register and read-pending pipeline.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            pend0_vld_q <= 1'b0;
            pend0_idx_q <= '0;
            pend1_vld_q <= 1'b0;
            pend1_idx_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (any_gnt) begin
                mem_we   <= win_we;
                mem_addr <= win_addr;
                mem_din  <= win_din;
            end else begin
                mem_we   <= 1'b0;
            end
            pend0_vld_q <= any_gnt & ~win_we;
            pend0_idx_q <= winner;
            pend1_vld_q <= pend0_vld_q;
            pend1_idx_q <= pend0_idx_q;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

    logic         clk;
    logic         rstn;
    logic [7:0]   req;
    logic [7:0]   we;
    logic [95:0]  addr;
    logic [127:0] din;
`ifdef MEM_ARB_LOCK_EN
    logic [7:0]   lock;
`endif
    logic [7:0]   gnt;
    logic [7:0]   rvalid;
    logic [15:0]  rdata;
    logic         mem_we;
    logic [11:0]  mem_addr;
    logic [15:0]  mem_din;
    logic [15:0]  mem_dout;

    logic [15:0]  ram [4096];

    int tests;
    int fails;

    mem_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .din      (din),
`ifdef MEM_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic set_core(input int i, input logic [11:0] a, input logic [15:0] d);
        addr[i*12 +: 12] = a;
        din[i*16 +: 16]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        req  = '0;
        we   = '0;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = 8'hFF;
        we   = '0;
        @(negedge clk);
        tests++; if (gnt !== 8'h00) begin fails++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL reset_rvalid: got %h expected 00", rvalid); end
        next_cycle();
        @(negedge clk);
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        tests++; if (mem_addr !== 12'd0) begin fails++; $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); end
        tests++; if (mem_din !== 16'd0) begin fails++; $display("FAIL reset_mem_din: got %h expected 0000", mem_din); end
        next_cycle();
        rstn = 1'b1;
        req  = '0;
    endtask

    task automatic test_read();
        set_core(0, 12'd4004, 16'h0000);
        req = 8'h01;
        we  = 8'h00;
        @(negedge clk);
        tests++; if (gnt !== 8'h01) begin fails++; $display("FAIL read_gnt: got %h expected 01", gnt); end
        next_cycle();
        req = 8'h00;
        @(negedge clk);
        tests++; if (mem_addr !== 12'd4004) begin fails++; $display("FAIL read_mem_addr: got %0d expected 4004", mem_addr); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL read_mem_we: got %b expected 0", mem_we); end
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL read_early_rvalid: got %h expected 00", rvalid); end
        next_cycle();
        @(negedge clk);
        tests++; if (rvalid !== 8'h01) begin fails++; $display("FAIL read_rvalid: got %h expected 01", rvalid); end
        tests++; if (rdata !== 16'd3) begin fails++; $display("FAIL read_rdata: got %h expected 0003", rdata); end
        tests++; if (mem_addr !== 12'd4004) begin fails++; $display("FAIL idle_hold_addr: got %0d expected 4004", mem_addr); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL idle_mem_we: got %b expected 0", mem_we); end
        next_cycle();
        @(negedge clk);
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL read_rvalid_single: got %h expected 00", rvalid); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        pulse_reset();
        req = 8'hFF;
        we  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = 8'h01 << i;
            @(negedge clk);
            tests++; if (gnt !== exp) begin fails++; $display("FAIL rr_gnt[%0d]: got %h expected %h", i, gnt, exp); end
            next_cycle();
        end
        req = 8'h00;
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    task automatic test_write_read();
        pulse_reset();
        set_core(3, 12'd3900, 16'h0042);
        req = 8'h08;
        we  = 8'h08;
        @(negedge clk);
        tests++; if (gnt !== 8'h08) begin fails++; $display("FAIL wr_gnt: got %h expected 08", gnt); end
        next_cycle();
        set_core(5, 12'd3900, 16'h0000);
        req = 8'h20;
        we  = 8'h00;
        @(negedge clk);
        tests++; if (gnt !== 8'h20) begin fails++; $display("FAIL rd_gnt: got %h expected 20", gnt); end
        tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
        tests++; if (mem_addr !== 12'd3900) begin fails++; $display("FAIL wr_mem_addr: got %0d expected 3900", mem_addr); end
        tests++; if (mem_din !== 16'h0042) begin fails++; $display("FAIL wr_mem_din: got %h expected 0042", mem_din); end
        next_cycle();
        req = 8'h00;
        @(negedge clk);
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL wr_no_rvalid: got %h expected 00", rvalid); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
        next_cycle();
        @(negedge clk);
        tests++; if (rvalid !== 8'h20) begin fails++; $display("FAIL rd_rvalid: got %h expected 20", rvalid); end
        tests++; if (rdata !== 16'h0042) begin fails++; $display("FAIL rd_rdata: got %h expected 0042", rdata); end
        next_cycle();
    endtask

    task automatic test_wrap();
        pulse_reset();
        req = 8'h20;
        we  = 8'h00;
        @(negedge clk);
        tests++; if (gnt !== 8'h20) begin fails++; $display("FAIL wrap_setup_gnt: got %h expected 20", gnt); end
        next_cycle();
        req = 8'h41;
        @(negedge clk);
        tests++; if (gnt !== 8'h40) begin fails++; $display("FAIL wrap_gnt6: got %h expected 40", gnt); end
        next_cycle();
        @(negedge clk);
        tests++; if (gnt !== 8'h01) begin fails++; $display("FAIL wrap_gnt0: got %h expected 01", gnt); end
        next_cycle();
        req = 8'hFF;
        @(negedge clk);
        tests++; if (gnt !== 8'h02) begin fails++; $display("FAIL wrap_ptr1: got %h expected 02", gnt); end
        next_cycle();
        req = 8'h00;
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        req = 8'h04;
        we  = 8'h00;
        @(negedge clk);
        tests++; if (gnt !== 8'h04) begin fails++; $display("FAIL mid_gnt: got %h expected 04", gnt); end
        next_cycle();
        req  = 8'h00;
        rstn = 1'b0;
        @(negedge clk);
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL mid_rvalid_in_reset: got %h expected 00", rvalid); end
        next_cycle();
        rstn = 1'b1;
        req  = 8'hFF;
        @(negedge clk);
        tests++; if (rvalid !== 8'h00) begin fails++; $display("FAIL mid_rvalid_dropped: got %h expected 00", rvalid); end
        tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL mid_mem_we: got %b expected 0", mem_we); end
        tests++; if (gnt !== 8'h01) begin fails++; $display("FAIL mid_ptr0: got %h expected 01", gnt); end
        next_cycle();
        req = 8'h00;
        for (int i = 0; i < 3; i++) next_cycle();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] lock_v [6] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
        logic [7:0] exp_g  [6] = '{8'h01, 8'h02, 8'h04, 8'h04, 8'h04, 8'h08};
        pulse_reset();
        req = 8'hFF;
        we  = 8'h00;
        for (int i = 0; i < 6; i++) begin
            lock = lock_v[i];
            @(negedge clk);
            tests++; if (gnt !== exp_g[i]) begin fails++; $display("FAIL lock_gnt[%0d]: got %h expected %h", i, gnt, exp_g[i]); end
            next_cycle();
        end
        req  = 8'h00;
        lock = 8'h00;
        for (int i = 0; i < 3; i++) next_cycle();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rstn  = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        din   = '0;
`ifdef MEM_ARB_LOCK_EN
        lock  = '0;
`endif
        for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
        ram[4004] = 16'd3;
        next_cycle();
        test_reset();
        test_read();
        test_round_robin();
        test_write_read();
        test_wrap();
        test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
